// File: rtl/score_arbiter_if.sv
// Player-pulse and score-display bundle between the pushbutton front end,
// the score arbiter and the 7-segment driver.
interface score_arbiter_if;
  logic       up_a_i;
  logic       down_a_i;
  logic       up_b_i;
  logic       down_b_i;
  logic       clear_i;
  logic [6:0] score_a_o;
  logic [6:0] score_b_o;
  logic [7:0] bcd_a_o;
  logic [7:0] bcd_b_o;
  logic [1:0] winner_o;
  logic       flash_o;
  logic       busy_o;

  modport master (
    output up_a_i, down_a_i, up_b_i, down_b_i, clear_i,
    input  score_a_o, score_b_o, bcd_a_o, bcd_b_o, winner_o, flash_o, busy_o
  );

  modport slave (
    input  up_a_i, down_a_i, up_b_i, down_b_i, clear_i,
    output score_a_o, score_b_o, bcd_a_o, bcd_b_o, winner_o, flash_o, busy_o
  );
endinterface

// File: rtl/score_arbiter.sv
// Two-player score controller: latches count pulses, round-robin arbitrates one
// saturating update per cycle, tracks PLAY/WIN. Define SCORE_WIN_BY_TWO_EN for win-by-two.
module score_arbiter #(
  parameter int WIN_SCORE    = 21,
  parameter int MAX_SCORE    = 99,
  parameter int FLASH_PERIOD = 500
) (
  input  logic            clk_1khz,
  input  logic            rst_ni,
  score_arbiter_if.slave  bus
);

  typedef enum logic {PLAY, WIN} state_t;

  localparam int CW = $clog2(FLASH_PERIOD + 1);

  state_t          state_q, state_d;
  logic            pa_up_q, pa_dn_q, pb_up_q, pb_dn_q;
  logic            pa_up_d, pa_dn_d, pb_up_d, pb_dn_d;
  logic            ptr_q, ptr_d;
  logic [6:0]      score_a_q, score_a_d, score_b_q, score_b_d;
  logic [7:0]      bcd_a_q, bcd_b_q;
  logic [1:0]      winner_q, winner_d;
  logic            flash_q, flash_d;
  logic [CW-1:0]   flash_cnt_q, flash_cnt_d;
  logic            req_a, req_b, grant_a, grant_b, win_hit;

  // A grant holding both up and down pending is a cancellation: score unchanged.
  function automatic logic [6:0] apply_update(input logic [6:0] s, input logic up, input logic dn);
    if (up && !dn && s < 7'(MAX_SCORE)) return s + 7'd1;
    if (dn && !up && s != 7'd0) return s - 7'd1;
    return s;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] s);
    return {4'(s / 7'd10), 4'(s % 7'd10)};
  endfunction

  function automatic logic win_check(input logic [6:0] s, input logic [6:0] opp);
`ifdef SCORE_WIN_BY_TWO_EN
    return (s >= 7'(WIN_SCORE)) && ({1'b0, s} >= ({1'b0, opp} + 8'd2));
`else
    return (s >= 7'(WIN_SCORE)) && (opp == opp);
`endif
  endfunction

  always_comb begin
    state_d     = state_q;
    pa_up_d     = pa_up_q;
    pa_dn_d     = pa_dn_q;
    pb_up_d     = pb_up_q;
    pb_dn_d     = pb_dn_q;
    ptr_d       = ptr_q;
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    winner_d    = winner_q;
    flash_d     = flash_q;
    flash_cnt_d = flash_cnt_q;
    win_hit     = 1'b0;
    req_a       = pa_up_q | pa_dn_q;
    req_b       = pb_up_q | pb_dn_q;
    grant_a     = (state_q == PLAY) && req_a && (!req_b || !ptr_q);
    grant_b     = (state_q == PLAY) && req_b && (!req_a || ptr_q);

    if (bus.clear_i) begin
      state_d     = PLAY;
      pa_up_d     = 1'b0;
      pa_dn_d     = 1'b0;
      pb_up_d     = 1'b0;
      pb_dn_d     = 1'b0;
      ptr_d       = 1'b0;
      score_a_d   = '0;
      score_b_d   = '0;
      winner_d    = 2'b00;
      flash_d     = 1'b0;
      flash_cnt_d = '0;
    end else if (state_q == WIN) begin
      pa_up_d = 1'b0;
      pa_dn_d = 1'b0;
      pb_up_d = 1'b0;
      pb_dn_d = 1'b0;
      if (flash_cnt_q == CW'(FLASH_PERIOD - 1)) begin
        flash_cnt_d = '0;
        flash_d     = ~flash_q;
      end else begin
        flash_cnt_d = flash_cnt_q + 1'b1;
      end
    end else begin
      // A new pulse re-sets its bit even when the old request is consumed now.
      pa_up_d = bus.up_a_i   | (pa_up_q & ~grant_a);
      pa_dn_d = bus.down_a_i | (pa_dn_q & ~grant_a);
      pb_up_d = bus.up_b_i   | (pb_up_q & ~grant_b);
      pb_dn_d = bus.down_b_i | (pb_dn_q & ~grant_b);
      if (req_a && req_b) ptr_d = ~ptr_q;
      if (grant_a) score_a_d = apply_update(score_a_q, pa_up_q, pa_dn_q);
      if (grant_b) score_b_d = apply_update(score_b_q, pb_up_q, pb_dn_q);
      if (grant_a && pa_up_q && !pa_dn_q) win_hit = win_check(score_a_d, score_b_q);
      if (grant_b && pb_up_q && !pb_dn_q) win_hit = win_check(score_b_d, score_a_q);
      if (win_hit) begin
        state_d     = WIN;
        winner_d    = grant_a ? 2'b01 : 2'b10;
        flash_d     = 1'b1;
        flash_cnt_d = '0;
        pa_up_d     = 1'b0;
        pa_dn_d     = 1'b0;
        pb_up_d     = 1'b0;
        pb_dn_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_1khz or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= PLAY;
      pa_up_q     <= 1'b0;
      pa_dn_q     <= 1'b0;
      pb_up_q     <= 1'b0;
      pb_dn_q     <= 1'b0;
      ptr_q       <= 1'b0;
      score_a_q   <= '0;
      score_b_q   <= '0;
      bcd_a_q     <= '0;
      bcd_b_q     <= '0;
      winner_q    <= 2'b00;
      flash_q     <= 1'b0;
      flash_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pa_up_q     <= pa_up_d;
      pa_dn_q     <= pa_dn_d;
      pb_up_q     <= pb_up_d;
      pb_dn_q     <= pb_dn_d;
      ptr_q       <= ptr_d;
      score_a_q   <= score_a_d;
      score_b_q   <= score_b_d;
      bcd_a_q     <= to_bcd(score_a_d);
      bcd_b_q     <= to_bcd(score_b_d);
      winner_q    <= winner_d;
      flash_q     <= flash_d;
      flash_cnt_q <= flash_cnt_d;
    end
  end

  assign bus.score_a_o = score_a_q;
  assign bus.score_b_o = score_b_q;
  assign bus.bcd_a_o   = bcd_a_q;
  assign bus.bcd_b_o   = bcd_b_q;
  assign bus.winner_o  = winner_q;
  assign bus.flash_o   = flash_q;
  assign bus.busy_o    = pa_up_q | pa_dn_q | pb_up_q | pb_dn_q;

endmodule

// File: tb/tb_score_arbiter.sv
// Bench for score_arbiter: directed scenarios plus random pulses, every cycle
// compared against a per-player behavioural model of the scoreboard rules.
module tb_score_arbiter;

  localparam int WIN = 21;
  localparam int MAX = 99;
  localparam int FP  = 500;

  logic clk_1khz = 1'b0;
  logic rst_ni   = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  score_arbiter_if bus ();

  score_arbiter #(.WIN_SCORE(WIN), .MAX_SCORE(MAX), .FLASH_PERIOD(FP)) dut (
    .clk_1khz (clk_1khz),
    .rst_ni   (rst_ni),
    .bus      (bus)
  );

  always #5 clk_1khz = ~clk_1khz;

  // Reference model: plain per-player arrays, index 0 = A, 1 = B.
  int m_score[2];
  bit m_up[2];
  bit m_dn[2];
  int m_ptr;
  bit m_win;
  int m_winner;
  int m_win_cycles;

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      m_score[p] = 0;
      m_up[p]    = 1'b0;
      m_dn[p]    = 1'b0;
    end
    m_ptr        = 0;
    m_win        = 1'b0;
    m_winner     = 0;
    m_win_cycles = 0;
  endfunction

  function automatic bit model_wins(int g);
`ifdef SCORE_WIN_BY_TWO_EN
    return (m_score[g] >= WIN) && (m_score[g] >= m_score[1-g] + 2);
`else
    return m_score[g] >= WIN;
`endif
  endfunction

  function automatic void model_step(bit ua, bit da, bit ub, bit db, bit clr);
    int g;
    bit u;
    bit d;
    bit in_up[2];
    bit in_dn[2];
    in_up[0] = ua; in_dn[0] = da; in_up[1] = ub; in_dn[1] = db;
    if (clr) begin
      model_reset();
      return;
    end
    if (m_win) begin
      m_win_cycles++;
      return;
    end
    g = -1;
    if ((m_up[0] || m_dn[0]) && (m_up[1] || m_dn[1])) begin
      g     = m_ptr;
      m_ptr = 1 - m_ptr;
    end else if (m_up[0] || m_dn[0]) g = 0;
    else if (m_up[1] || m_dn[1]) g = 1;
    if (g >= 0) begin
      u = m_up[g];
      d = m_dn[g];
      m_up[g] = 1'b0;
      m_dn[g] = 1'b0;
      if (u && !d) begin
        if (m_score[g] < MAX) m_score[g]++;
        if (model_wins(g)) begin
          m_win        = 1'b1;
          m_winner     = g + 1;
          m_win_cycles = 0;
        end
      end else if (d && !u && m_score[g] > 0) begin
        m_score[g]--;
      end
    end
    for (int p = 0; p < 2; p++) begin
      m_up[p] = m_up[p] | in_up[p];
      m_dn[p] = m_dn[p] | in_dn[p];
    end
    if (m_win) begin
      for (int p = 0; p < 2; p++) begin
        m_up[p] = 1'b0;
        m_dn[p] = 1'b0;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string phase);
    logic [7:0] e_bcd_a;
    logic [7:0] e_bcd_b;
    bit         e_flash;
    e_bcd_a = 8'((m_score[0] / 10) * 16 + m_score[0] % 10);
    e_bcd_b = 8'((m_score[1] / 10) * 16 + m_score[1] % 10);
    e_flash = m_win && (((m_win_cycles / FP) % 2) == 0);
    check({phase, ".score_a"}, {1'b0, bus.score_a_o}, 8'(m_score[0]));
    check({phase, ".score_b"}, {1'b0, bus.score_b_o}, 8'(m_score[1]));
    check({phase, ".bcd_a"},   bus.bcd_a_o, e_bcd_a);
    check({phase, ".bcd_b"},   bus.bcd_b_o, e_bcd_b);
    check({phase, ".winner"},  {6'd0, bus.winner_o}, 8'(m_winner));
    check({phase, ".flash"},   {7'd0, bus.flash_o}, {7'd0, e_flash});
    check({phase, ".busy"},    {7'd0, bus.busy_o},
          {7'd0, m_up[0] | m_dn[0] | m_up[1] | m_dn[1]});
  endtask

  // One clock: present pulses, advance the model, sample 1 time unit after the edge.
  task automatic applyStimulus(input string phase, input bit ua, input bit da,
                               input bit ub, input bit db, input bit clr);
    bus.up_a_i   = ua;
    bus.down_a_i = da;
    bus.up_b_i   = ub;
    bus.down_b_i = db;
    bus.clear_i  = clr;
    model_step(ua, da, ub, db, clr);
    @(posedge clk_1khz);
    #1;
    bus.up_a_i   = 1'b0;
    bus.down_a_i = 1'b0;
    bus.up_b_i   = 1'b0;
    bus.down_b_i = 1'b0;
    bus.clear_i  = 1'b0;
    check_all(phase);
  endtask

  task automatic idle(input string phase, input int n);
    for (int i = 0; i < n; i++) applyStimulus(phase, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit ua, da, ub, db, clr;
    bus.up_a_i   = 1'b0;
    bus.down_a_i = 1'b0;
    bus.up_b_i   = 1'b0;
    bus.down_b_i = 1'b0;
    bus.clear_i  = 1'b0;
    model_reset();

    // Reset state
    #2;
    check_all("reset");
    #5 rst_ni = 1'b1;

    // Single uncontested up: busy one cycle, score visible after the next edge
    applyStimulus("first_up", 1, 0, 0, 0, 0);
    check("first_up.busy_const", {7'd0, bus.busy_o}, 8'd1);
    applyStimulus("first_up", 0, 0, 0, 0, 0);
    check("first_up.score_const", {1'b0, bus.score_a_o}, 8'd1);
    check("first_up.bcd_const", bus.bcd_a_o, 8'h01);
    check("first_up.busy_low", {7'd0, bus.busy_o}, 8'd0);

    // Contested pairs: grant order A,B / B,A / A,B
    applyStimulus("clear0", 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus("contest", 1, 0, 1, 0, 0);
      applyStimulus("contest", 0, 0, 0, 0, 0);
      if (k == 1) begin
        check("contest.first_b", {1'b0, bus.score_b_o}, 8'(k + 1));
        check("contest.wait_a",  {1'b0, bus.score_a_o}, 8'(k));
      end else begin
        check("contest.first_a", {1'b0, bus.score_a_o}, 8'(k + 1));
        check("contest.wait_b",  {1'b0, bus.score_b_o}, 8'(k));
      end
      idle("contest", 4);
    end
    check("contest.final_a", {1'b0, bus.score_a_o}, 8'd3);
    check("contest.final_b", {1'b0, bus.score_b_o}, 8'd3);

    // Cancellation at A=5, floor at B=0
    applyStimulus("clear1", 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("pump_a", 1, 0, 0, 0, 0);
      applyStimulus("pump_a", 0, 0, 0, 0, 0);
    end
    applyStimulus("cancel", 1, 1, 0, 0, 0);
    idle("cancel", 2);
    check("cancel.a_stays", {1'b0, bus.score_a_o}, 8'd5);
    applyStimulus("floor_b", 0, 0, 0, 1, 0);
    idle("floor_b", 2);
    check("floor_b.b_zero", {1'b0, bus.score_b_o}, 8'd0);

    // Random pulses
    for (int i = 0; i < 600; i++) begin
      ua  = ($urandom_range(0, 99) < 20);
      da  = ($urandom_range(0, 99) < 10);
      ub  = ($urandom_range(0, 99) < 20);
      db  = ($urandom_range(0, 99) < 10);
      clr = ($urandom_range(0, 199) == 0);
      applyStimulus("random", ua, da, ub, db, clr);
    end

`ifdef SCORE_WIN_BY_TWO_EN
    // Tied at 20: 21 is not enough, 22 wins
    applyStimulus("clear2", 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus("pump_ab", 1, 0, 1, 0, 0);
      idle("pump_ab", 2);
    end
    applyStimulus("by_two", 1, 0, 0, 0, 0);
    idle("by_two", 1);
    check("by_two.no_win", {6'd0, bus.winner_o}, 8'd0);
    applyStimulus("by_two", 1, 0, 0, 0, 0);
    idle("by_two", 1);
    check("by_two.win_a", {6'd0, bus.winner_o}, 8'd1);
`endif

    // A reaches WIN_SCORE: win, flash high for FP cycles, inputs ignored
    applyStimulus("clear3", 0, 0, 0, 0, 1);
    for (int i = 0; i < WIN - 1; i++) begin
      applyStimulus("pump_a20", 1, 0, 0, 0, 0);
      applyStimulus("pump_a20", 0, 0, 0, 0, 0);
    end
    applyStimulus("win", 1, 0, 0, 0, 0);
    applyStimulus("win", 0, 0, 0, 0, 0);
    check("win.score_a", {1'b0, bus.score_a_o}, 8'(WIN));
    check("win.winner", {6'd0, bus.winner_o}, 8'd1);
    check("win.flash_hi", {7'd0, bus.flash_o}, 8'd1);
    for (int i = 0; i < FP - 1; i++) begin
      applyStimulus("win_hold", ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0), 0, 0);
    end
    check("win.flash_still_hi", {7'd0, bus.flash_o}, 8'd1);
    applyStimulus("win_hold", 0, 0, 1, 0, 0);
    check("win.flash_lo", {7'd0, bus.flash_o}, 8'd0);
    check("win.frozen_a", {1'b0, bus.score_a_o}, 8'(WIN));
    check("win.frozen_b", {1'b0, bus.score_b_o}, 8'd0);

    // Clear during WIN beats a same-cycle up_b pulse
    applyStimulus("clear_win", 0, 0, 1, 0, 1);
    idle("clear_win", 2);
    check("clear_win.b", {1'b0, bus.score_b_o}, 8'd0);
    check("clear_win.winner", {6'd0, bus.winner_o}, 8'd0);
    check("clear_win.flash", {7'd0, bus.flash_o}, 8'd0);

    // Asynchronous reset mid-run
    applyStimulus("pre_rst", 1, 0, 0, 0, 0);
    applyStimulus("pre_rst", 0, 0, 1, 0, 0);
    bus.up_a_i = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.score_a", {1'b0, bus.score_a_o}, 8'd0);
    bus.up_a_i = 1'b0;
    @(negedge clk_1khz);
    rst_ni = 1'b1;
    idle("post_rst", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
